// File: rtl/rv_ex_pkg.sv
// Shared execute-stage definitions: funct3 codes, MDU FSM states, forwarding selects, ALU control.
// No state here; alu_control is a pure decode used by the top level.
package rv_ex_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b01;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_BUSY = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  // ALUOp: 00 address add, 01 branch compare, 10 R-type, 11 I-type (no SUB form).
  function automatic alu_op_t alu_control(input logic [1:0] alu_op,
                                          input logic [2:0] funct3,
                                          input logic       funct7_5);
    alu_op_t op;
    op = ALU_ADD;
    if (alu_op == 2'b01) begin
      op = ALU_SUB;
    end else if (alu_op[1]) begin
      case (funct3)
        3'b000:  op = (funct7_5 && !alu_op[0]) ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV M-extension unit: XLEN-cycle shift-add multiply / restoring divide.
// Latency XLEN+1 cycles to DONE (1 for divide special cases); flush or rst aborts with no result write.
module mdu_iter
  import rv_ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  mdu_state_t        state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd_q;
  logic [2:0]        f3_q;
  logic              neg_q, neg_a_q;
  logic [XLEN-1:0]   result_q;

  logic            is_div, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b, special_res;
  logic            div_zero, div_ovf, special;

  assign is_div   = funct3[2];
  assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign neg_a    = a_signed & op_a[XLEN-1];
  assign neg_b    = b_signed & op_b[XLEN-1];
  assign mag_a    = neg_a ? -op_a : op_a;
  assign mag_b    = neg_b ? -op_b : op_b;
  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign special  = div_zero || div_ovf;
  // funct3[1] selects the remainder flavour of the divide ops.
  assign special_res = funct3[1] ? (div_zero ? op_a : '0)
                                 : (div_zero ? '1   : op_a);

  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (f3_q[2])
      acc_step = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
    prod_fix = neg_q ? -acc_step : acc_step;
    quo      = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem      = neg_a_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (f3_q[2])
      final_res = f3_q[1] ? rem : quo;
    else
      final_res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (start) state_nxt = special ? MDU_DONE : MDU_BUSY;
      MDU_BUSY: if (cnt == CW'(1)) state_nxt = MDU_DONE;
      MDU_DONE: state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
    if (flush) state_nxt = MDU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        MDU_IDLE: if (start) begin
          f3_q    <= funct3;
          neg_q   <= neg_a ^ neg_b;
          neg_a_q <= neg_a;
          if (special) begin
            result_q <= special_res;
            cnt      <= '0;
          end else begin
            cnt    <= CW'(XLEN);
            acc    <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opnd_q <= is_div ? mag_b : mag_a;
          end
        end
        MDU_BUSY: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign done   = (state == MDU_DONE);
  assign busy   = (state != MDU_IDLE);

endmodule

// File: rtl/execute_m_stage.sv
// RV32IM/RV64IM execute stage: forwarding, ALU, branch resolution and iterative MDU.
// Non-M ops are combinational; M-ops stall the front end until the MDU reaches DONE.
module execute_m_stage
  import rv_ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [2:0]      funct3_in,
  input  logic            funct7_5_in,
  input  logic            mext_in,
  input  logic            RegWrite_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic            MemToReg_in,
  input  logic            ALUSrc_in,
  input  logic            Branch_in,
  input  logic [1:0]      ALUOp_in,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush_in,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] rs2_data_forwarded_out,
  output logic [XLEN-1:0] branch_target_out,
  output logic [4:0]      rd_out,
  output logic            RegWrite_out,
  output logic            MemRead_out,
  output logic            MemWrite_out,
  output logic            MemToReg_out,
  output logic            branch_taken_out,
  output logic            stall_out,
  output logic            mdu_busy_out
);

  localparam int SW = $clog2(XLEN);

  // Register indices are consumed by the external forwarding unit, not here.
  logic unused_idx;
  assign unused_idx = ^{rs1_in, rs2_in};

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res, mdu_result;
  logic [SW-1:0]   shamt;
  alu_op_t         alu_op;
  logic            eq, lt, ltu, cond, mdu_done, kill;

  always_comb begin
    case (forwardA)
      FWD_EXMEM: fwd_a = ex_mem_alu_result;
      FWD_WB:    fwd_a = wb_data;
      default:   fwd_a = rs1_data_in;
    endcase
    case (forwardB)
      FWD_EXMEM: fwd_b = ex_mem_alu_result;
      FWD_WB:    fwd_b = wb_data;
      default:   fwd_b = rs2_data_in;
    endcase
  end

  assign alu_b  = ALUSrc_in ? imm_in : fwd_b;
  assign shamt  = alu_b[SW-1:0];
  assign alu_op = alu_control(ALUOp_in, funct3_in, funct7_5_in);

  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_res = fwd_a - alu_b;
      ALU_SLL:  alu_res = fwd_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd_a < alu_b};
      ALU_XOR:  alu_res = fwd_a ^ alu_b;
      ALU_SRL:  alu_res = fwd_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(fwd_a) >>> shamt);
      ALU_OR:   alu_res = fwd_a | alu_b;
      ALU_AND:  alu_res = fwd_a & alu_b;
      default:  alu_res = fwd_a + alu_b;
    endcase
  end

  assign eq  = (fwd_a == fwd_b);
  assign lt  = ($signed(fwd_a) < $signed(fwd_b));
  assign ltu = (fwd_a < fwd_b);

  always_comb begin
    case (funct3_in)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = !lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (valid_in & mext_in),
    .flush  (flush_in),
    .funct3 (funct3_in),
    .op_a   (fwd_a),
    .op_b   (fwd_b),
    .result (mdu_result),
    .done   (mdu_done),
    .busy   (mdu_busy_out)
  );

  // A synchronous reset in the same cycle behaves like a flush for write suppression.
  assign kill      = flush_in | rst;
  assign stall_out = valid_in & mext_in & !mdu_done & !kill;

  assign alu_result_out         = (valid_in & mext_in & mdu_done) ? mdu_result : alu_res;
  assign rs2_data_forwarded_out = fwd_b;
  assign branch_target_out      = pc_in + imm_in;
  assign branch_taken_out       = valid_in & !flush_in & Branch_in & !mext_in & cond;
  assign rd_out                 = rd_in;
  assign MemToReg_out           = MemToReg_in;
  assign RegWrite_out           = valid_in & !kill & !stall_out & RegWrite_in;
  assign MemRead_out            = valid_in & !kill & !stall_out & MemRead_in;
  assign MemWrite_out           = valid_in & !kill & !stall_out & MemWrite_in;

endmodule

// File: tb/tb_execute_m_stage.sv
// Directed self-checking bench for execute_m_stage at XLEN = 32.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_execute_m_stage;
  localparam int XLEN = 32;

  logic            clk, rst, valid_in;
  logic [XLEN-1:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
  logic [4:0]      rs1_in, rs2_in, rd_in;
  logic [2:0]      funct3_in;
  logic            funct7_5_in, mext_in;
  logic            RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, Branch_in;
  logic [1:0]      ALUOp_in, forwardA, forwardB;
  logic [XLEN-1:0] ex_mem_alu_result, wb_data;
  logic            flush_in;
  logic [XLEN-1:0] alu_result_out, rs2_data_forwarded_out, branch_target_out;
  logic [4:0]      rd_out;
  logic            RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out;
  logic            branch_taken_out, stall_out, mdu_busy_out;

  int checks = 0;
  int failures = 0;

  execute_m_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .funct3_in(funct3_in),
    .funct7_5_in(funct7_5_in), .mext_in(mext_in), .RegWrite_in(RegWrite_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
    .ALUSrc_in(ALUSrc_in), .Branch_in(Branch_in), .ALUOp_in(ALUOp_in),
    .forwardA(forwardA), .forwardB(forwardB), .ex_mem_alu_result(ex_mem_alu_result),
    .wb_data(wb_data), .flush_in(flush_in), .alu_result_out(alu_result_out),
    .rs2_data_forwarded_out(rs2_data_forwarded_out), .branch_target_out(branch_target_out),
    .rd_out(rd_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .MemToReg_out(MemToReg_out),
    .branch_taken_out(branch_taken_out), .stall_out(stall_out), .mdu_busy_out(mdu_busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    valid_in = 0; pc_in = 0; rs1_data_in = 0; rs2_data_in = 0; imm_in = 0;
    rs1_in = 0; rs2_in = 0; rd_in = 0; funct3_in = 0; funct7_5_in = 0; mext_in = 0;
    RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemToReg_in = 0;
    ALUSrc_in = 0; Branch_in = 0; ALUOp_in = 0; forwardA = 0; forwardB = 0;
    ex_mem_alu_result = 0; wb_data = 0; flush_in = 0;
  endtask

  task automatic set_op(input logic mext, input logic [2:0] f3, input logic [1:0] aluop,
                        input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    valid_in = 1; mext_in = mext; funct3_in = f3; ALUOp_in = aluop;
    rs1_data_in = a; rs2_data_in = b; RegWrite_in = 1; rd_in = 5'd9;
  endtask

  // Counts stall cycles from the accept cycle, then checks the DONE-cycle result.
  task automatic run_mop(input string tag, input logic [31:0] exp, input int exp_stall,
                         input bit chg_fwd);
    int n = 0;
    int bad_wr = 0;
    #1;
    while (stall_out === 1'b1 && n < 200) begin
      n++;
      if (RegWrite_out !== 1'b0) bad_wr++;
      if (chg_fwd && n == 3) ex_mem_alu_result = 32'd5;
      @(negedge clk); #1;
    end
    check({tag, "_stall_cycles"}, n, exp_stall);
    check({tag, "_bubble"}, bad_wr, 0);
    check({tag, "_result"}, alu_result_out, exp);
    check({tag, "_wr"}, RegWrite_out, 1);
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("rst_alu", alu_result_out, 0);
    check("rst_stall", stall_out, 0);
    check("rst_busy", mdu_busy_out, 0);
    check("rst_wr", RegWrite_out, 0);
    check("rst_taken", branch_taken_out, 0);

    @(negedge clk);
    set_op(0, 3'b000, 2'b10, 32'd10, 32'd20); #1;
    check("add_res", alu_result_out, 32'd30);
    check("add_stall", stall_out, 0);
    check("add_wr", RegWrite_out, 1);
    funct7_5_in = 1; #1;
    check("sub_res", alu_result_out, 32'hFFFF_FFF6);
    ALUOp_in = 2'b11; funct7_5_in = 0; ALUSrc_in = 1; imm_in = 32'hFFFF_FFFC; #1;
    check("addi_res", alu_result_out, 32'd6);

    @(negedge clk);
    set_op(1, 3'b000, 2'b10, 32'd7, 32'hFFFF_FFFD);      run_mop("mul", 32'hFFFF_FFEB, 33, 0);
    set_op(1, 3'b011, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF); run_mop("mulhu", 32'hFFFF_FFFE, 33, 0);
    set_op(1, 3'b001, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF); run_mop("mulh", 32'h0, 33, 0);
    set_op(1, 3'b010, 2'b10, 32'hFFFF_FFFF, 32'd2);      run_mop("mulhsu", 32'hFFFF_FFFF, 33, 0);
    set_op(1, 3'b100, 2'b10, 32'd7, 32'd0);              run_mop("div0", 32'hFFFF_FFFF, 1, 0);
    set_op(1, 3'b110, 2'b10, 32'd7, 32'd0);              run_mop("rem0", 32'd7, 1, 0);
    set_op(1, 3'b100, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF); run_mop("divovf", 32'h8000_0000, 1, 0);
    set_op(1, 3'b110, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF); run_mop("removf", 32'h0, 1, 0);
    set_op(1, 3'b100, 2'b10, 32'hFFFF_FFEC, 32'd3);      run_mop("div_neg", 32'hFFFF_FFFA, 33, 0);
    set_op(1, 3'b110, 2'b10, 32'hFFFF_FFEC, 32'd3);      run_mop("rem_neg", 32'hFFFF_FFFE, 33, 0);
    set_op(1, 3'b101, 2'b10, 32'd0, 32'd7);
    forwardA = 2'b10; ex_mem_alu_result = 32'd100;       run_mop("divu_fwd", 32'd14, 33, 1);
    set_op(1, 3'b111, 2'b10, 32'd0, 32'd7);
    forwardA = 2'b10; ex_mem_alu_result = 32'd100;       run_mop("remu_fwd", 32'd2, 33, 1);

    // Flush in BUSY cycle 10, then reset in BUSY cycle 10.
    for (int k = 0; k < 2; k++) begin
      set_op(1, 3'b000, 2'b10, 32'd3, 32'd4);
      repeat (10) @(negedge clk);
      if (k == 0) flush_in = 1; else rst = 1;
      #1;
      check(k == 0 ? "flush_stall" : "rstmid_stall", stall_out, 0);
      check(k == 0 ? "flush_wr" : "rstmid_wr", RegWrite_out, 0);
      @(negedge clk);
      clear_inputs(); rst = 0; #1;
      check(k == 0 ? "flush_idle" : "rstmid_idle", mdu_busy_out, 0);
      @(negedge clk);
    end

    // Flush in the DONE cycle suppresses the write.
    set_op(1, 3'b000, 2'b10, 32'd3, 32'd4);
    begin
      int n = 0;
      #1;
      while (stall_out === 1'b1 && n < 200) begin n++; @(negedge clk); #1; end
      check("fdone_stall_cycles", n, 33);
    end
    flush_in = 1; #1;
    check("fdone_wr", RegWrite_out, 0);
    @(negedge clk);

    set_op(0, 3'b000, 2'b01, 32'd15, 32'd15);
    Branch_in = 1; RegWrite_in = 0; pc_in = 32'd200; imm_in = 32'd16; #1;
    check("beq_taken", branch_taken_out, 1);
    check("beq_target", branch_target_out, 32'd216);
    funct3_in = 3'b001; #1;
    check("bne_taken", branch_taken_out, 0);
    funct3_in = 3'b100; rs1_data_in = 32'hFFFF_FFFF; rs2_data_in = 32'd1; #1;
    check("blt_taken", branch_taken_out, 1);
    funct3_in = 3'b110; #1;
    check("bltu_taken", branch_taken_out, 0);
    funct3_in = 3'b100; flush_in = 1; #1;
    check("blt_flushed", branch_taken_out, 0);
    pc_in = 32'hFFFF_FFF0; imm_in = 32'h20; #1;
    check("target_wrap", branch_target_out, 32'h10);

    @(negedge clk);
    clear_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_m_stage.md
# execute_m_stage

Parametrised RV32IM execute stage for the five-stage pipeline, sitting between the ID/EX and EX/MEM registers. It performs single-cycle ALU and branch resolution with EX/MEM and WB forwarding. It adds an iterative multiply/divide unit for the M extension, which stalls the front of the pipeline until its result is ready.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- valid_in  in  1  ID/EX holds a real instruction.
- pc_in, rs1_data_in, rs2_data_in, imm_in  in  XLEN  ID/EX operands.
- rs1_in, rs2_in, rd_in  in  5  register indices.
- funct3_in  in  3; funct7_5_in  in  1; mext_in  in  1  (R-type with funct7 = 0000001).
- RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, Branch_in  in  1 each; ALUOp_in  in  2.
- forwardA, forwardB  in  2  forwarding selects: 00 register file, 10 EX/MEM, 01 WB.
- ex_mem_alu_result, wb_data  in  XLEN  forwarding sources.
- flush_in  in  1  kills the instruction in EX, including any in-flight M-op.
- alu_result_out, rs2_data_forwarded_out, branch_target_out  out  XLEN.
- rd_out  out  5; RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out, branch_taken_out  out  1.
- stall_out  out  1  hold PC, IF/ID and ID/EX, and insert a bubble into EX/MEM.
- mdu_busy_out  out  1  the FSM is not IDLE.

## Operation
- Non-M instructions: combinational path identical to the existing RV32I stage.
  - Forwarding muxes feed the ALU; the ALUSrc mux selects imm.
  - Branch resolution covers BEQ, BNE, BLT, BGE, BLTU and BGEU.
  - branch_target_out = pc_in + imm_in, wrapping modulo 2^XLEN.
  - branch_taken_out is forced to 0 when valid_in = 0 or flush_in = 1.
- M instructions (valid_in & mext_in), FSM with states IDLE, BUSY and DONE:
  - In IDLE on an M-op: latch the forwarded rs1/rs2 values, funct3, operand signs and magnitudes. Load counter = XLEN, go to BUSY.
  - Divide special cases skip BUSY and go straight to DONE:
    - divisor 0: quotient all-ones, remainder = dividend.
    - DIV/REM of (−2^(XLEN−1)) by −1: quotient = dividend, remainder = 0.
  - In BUSY: one shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per cycle. Counter decrements; at counter = 1, go to DONE.
  - In DONE: alu_result_out = result register. For MUL, MULH, MULHSU and MULHU, select the low or high half of the sign-corrected 2·XLEN product. Then return to IDLE.
- stall_out = valid_in & mext_in & (state != DONE) & !flush_in.
- While stall_out = 1: RegWrite_out, MemRead_out and MemWrite_out are forced to 0 (bubble).
- Operands are latched at acceptance, so changes on the forwarding sources during the stall have no effect.
- flush_in in any state: next state is IDLE, counter cleared, no result written.
- rst: state IDLE, counter 0, result register 0. With valid_in = 0 after reset, every output is 0 except pass-throughs of the inputs.

## Timing
- Non-M instructions: zero latency, fully combinational; stall_out stays 0.
- Normal M-op: stall_out is high for exactly XLEN + 1 cycles (the accept cycle plus XLEN BUSY cycles). The result is valid with RegWrite_out = 1 in the following DONE cycle.
- Divide special case: stall_out is high for 1 cycle; DONE follows in the next cycle.
- Back-to-back M-ops: after DONE, the next M-op is accepted in the IDLE cycle that immediately follows, with no extra bubble.
- flush_in and rst take priority over every state transition. A flush or reset in the DONE cycle suppresses the write.

## Structure
- Shared header rv_ex_pkg holds:
  - M funct3 codes: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
  - Branch funct3 codes.
  - FSM state encodings.
  - Forwarding-select constants.
- Sub-module mdu_iter holds the FSM, counter, operand/result registers and special-case detection. The top level reuses the existing alu, alu_control, branch_unit, mux and adder.

## Test plan
- ADD 10 + 20, ALUOp = 10, XLEN = 32 -> alu_result_out = 30, stall_out = 0 throughout.
- MUL 7 × −3 -> stall_out high for 33 cycles with RegWrite_out = 0; DONE gives 0xFFFFFFEB with RegWrite_out = 1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands (−1 × −1) -> 0x00000000.
- DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7, DIV 0x80000000 / −1 -> 0x80000000; each stalls 1 cycle.
- DIVU with forwardA = 10, ex_mem_alu_result = 100 and rs2 = 7, with ex_mem_alu_result changed to 5 mid-stall -> result 14; REMU gives 2.
- flush_in in BUSY cycle 10 -> stall_out = 0 the same cycle, no write, IDLE next cycle; rst mid-op gives the same. BEQ 15 = 15 at pc 200 with imm 16 -> taken, target 216.
